// File: rtl/four_two.sv
// Registered 4-to-2 priority encoder (d > c > b > a) with per-input synchronizer
// chains, valid/multi-hot flags and a one-cycle strobe on any code change.
module four_two #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e0,
    output logic e1,
    output logic valid,
    output logic multi,
    output logic changed
);

    logic [3:0] req_raw;
    logic [3:0] req_sync;
    logic [1:0] enc_code;
    logic       enc_valid;
    logic       enc_multi;
    logic [2:0] ones;

    assign req_raw = {d, c, b, a};

    generate
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_stages
            $error("four_two: SYNC_STAGES must be in 0..3");
        end

        if (SYNC_STAGES == 0) begin : g_no_sync
            assign req_sync = req_raw;
        end else begin : g_sync
            logic [3:0] chain [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        chain[i] <= '0;
                    end
                end else begin
                    chain[0] <= req_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign req_sync = chain[SYNC_STAGES-1];
        end
    endgenerate

    assign ones = 3'(req_sync[0]) + 3'(req_sync[1]) + 3'(req_sync[2]) + 3'(req_sync[3]);

    always_comb begin
        enc_code = 2'b00;
        if (req_sync[3]) begin
            enc_code = 2'b11;
        end else if (req_sync[2]) begin
            enc_code = 2'b10;
        end else if (req_sync[1]) begin
            enc_code = 2'b01;
        end
        enc_valid = |req_sync;
        enc_multi = (ones >= 3'd2);
    end

    // The output register itself is the previous-value reference for the strobe;
    // multi is deliberately left out of the comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1      <= 1'b0;
            e0      <= 1'b0;
            valid   <= 1'b0;
            multi   <= 1'b0;
            changed <= 1'b0;
        end else begin
            e1      <= enc_code[1];
            e0      <= enc_code[0];
            valid   <= enc_valid;
            multi   <= enc_multi;
            changed <= ({enc_valid, enc_code} != {valid, e1, e0});
        end
    end

endmodule

// File: tb/tb_four_two.sv
// Directed self-checking bench for four_two: runs SYNC_STAGES = 0, 2 and 3 side
// by side on the same inputs so the latency of each can be checked per edge.
module tb_four_two;

    logic clk;
    logic rst_n;
    logic a, b, c, d;

    logic e0_0, e1_0, valid_0, multi_0, changed_0;
    logic e0_2, e1_2, valid_2, multi_2, changed_2;
    logic e0_3, e1_3, valid_3, multi_3, changed_3;

    logic [4:0] out0, out2, out3;
    assign out0 = {e1_0, e0_0, valid_0, multi_0, changed_0};
    assign out2 = {e1_2, e0_2, valid_2, multi_2, changed_2};
    assign out3 = {e1_3, e0_3, valid_3, multi_3, changed_3};

    int n_cmp = 0;
    int n_err = 0;

    // Expected settled state {e1,e0,valid,multi} before the current step.
    logic [3:0] cur;

    four_two #(.SYNC_STAGES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .e0(e0_0), .e1(e1_0), .valid(valid_0), .multi(multi_0), .changed(changed_0)
    );

    four_two dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .e0(e0_2), .e1(e1_2), .valid(valid_2), .multi(multi_2), .changed(changed_2)
    );

    four_two #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .e0(e0_3), .e1(e1_3), .valid(valid_3), .multi(multi_3), .changed(changed_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] expect_out(input int k, input int lat, input logic [3:0] nxt);
        logic [3:0] v;
        v = (k >= lat) ? nxt : cur;
        return {v, (k == lat) && (nxt[3:1] != cur[3:1])};
    endfunction

    // Ten edges after an input change: each instance must hold the old state until
    // its latency edge, then show the new state with a one-edge strobe if the code moved.
    task automatic run_edges(input string tag, input logic [3:0] nxt);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s/s0/e%0d", tag, k), out0, expect_out(k, 1, nxt));
            check($sformatf("%s/s2/e%0d", tag, k), out2, expect_out(k, 3, nxt));
            check($sformatf("%s/s3/e%0d", tag, k), out3, expect_out(k, 4, nxt));
        end
        cur = nxt;
    endtask

    task automatic apply_stimulus(input string tag, input logic [3:0] dcba, input logic [3:0] nxt);
        {d, c, b, a} = dcba;
        run_edges(tag, nxt);
    endtask

    initial begin
        rst_n = 1'b0;
        {d, c, b, a} = 4'b1111;
        cur = 4'b0000;

        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst/s0/e%0d", k), out0, 5'b00000);
            check($sformatf("rst/s2/e%0d", k), out2, 5'b00000);
            check($sformatf("rst/s3/e%0d", k), out3, 5'b00000);
        end

        rst_n = 1'b1;
        apply_stimulus("release", 4'b0000, 4'b0000);

        // One-hot sweep; expected {e1,e0,valid,multi}
        apply_stimulus("a",    4'b0001, 4'b0010);
        apply_stimulus("b",    4'b0010, 4'b0110);
        apply_stimulus("c",    4'b0100, 4'b1010);
        apply_stimulus("d",    4'b1000, 4'b1110);
        apply_stimulus("idle", 4'b0000, 4'b0000);
        apply_stimulus("a2",   4'b0001, 4'b0010);
        apply_stimulus("a2z",  4'b0000, 4'b0000);

        // Multi-hot priority
        apply_stimulus("m0110", 4'b0110, 4'b1011);
        apply_stimulus("m1111", 4'b1111, 4'b1111);
        apply_stimulus("m1001", 4'b1001, 4'b1111);
        apply_stimulus("m0011", 4'b0011, 4'b0111);

        // Mid-stream asynchronous reset pulse, 2 ns wide, between edges
        {d, c, b, a} = 4'b1100;
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check("async_rst/s0", out0, 5'b00000);
        check("async_rst/s2", out2, 5'b00000);
        check("async_rst/s3", out3, 5'b00000);
        #1;
        rst_n = 1'b1;
        cur = 4'b0000;
        run_edges("post_rst", 4'b1111);

        apply_stimulus("toggle_a", 4'b0001, 4'b0010);
        apply_stimulus("final",    4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/four_two.md
# four_two

Registered 4-to-2 priority encoder with input synchronization and status flags. It takes four request lines (a..d) and produces a 2-bit index (e1:e0) of the highest-priority active line. It also produces a valid flag, a multi-hot flag and a change strobe. It sits at the boundary between asynchronous request/status lines and synchronous control logic.

## Interface
- SYNC_STAGES, default 2: number of synchronizer flops on each input, legal range 0..3; 0 means inputs are sampled directly by the encode register.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low; one clock domain (clk).
- a  input  1  request line, index 0, lowest priority.
- b  input  1  request line, index 1.
- c  input  1  request line, index 2.
- d  input  1  request line, index 3, highest priority.
- e0  output  1  encoded index bit 0.
- e1  output  1  encoded index bit 1.
- valid  output  1  at least one request line was active in the encoded sample.
- multi  output  1  more than one request line was active in the encoded sample.
- changed  output  1  single-cycle strobe; {valid,e1,e0} differs from the previous cycle's value.

## Operation
- Each of a, b, c and d passes through its own SYNC_STAGES-deep flop chain. The chains reset to 0.
- The encode stage operates on the synchronized vector {d,c,b,a}.
- Priority is d > c > b > a:
  - d=1 -> {e1,e0}=11
  - else c=1 -> 10
  - else b=1 -> 01
  - else a=1 -> 00
- If no line is active, {e1,e0}=00 and valid=0.
- If any line is active, valid=1.
- multi=1 when two or more synchronized lines are 1, independent of which line wins.
- Outputs e1, e0, valid and multi are registered; there are no combinational paths from inputs to outputs.
- The changed register holds the previous {valid,e1,e0}. The changed output is 1 for exactly one cycle after any difference in {valid,e1,e0}. A change in multi alone does not assert changed.
- A SYNC_STAGES value outside 0..3 is a synthesis-time error (generate-time check).

## Timing
- Asserting rst_n=0 asynchronously clears, with no clock edge required:
  - all synchronizer flops
  - e0=0, e1=0, valid=0, multi=0, changed=0
  - the previous-value register = 000
- Release of rst_n is sampled on clk. The first capture occurs at the first rising edge after deassertion.
- Latency from an input change to the outputs is SYNC_STAGES+1 rising edges. Inputs must be stable for the setup time before an edge for that latency to hold; otherwise the latency is one cycle more.
- changed rises in the same cycle the new {valid,e1,e0} appears and falls on the next edge, unless the value changes again.
- Changes in several inputs that arrive at the same edge are encoded together; there is no intermediate code.
- Reset asserted mid-operation discards all in-flight samples. After release, outputs reflect only inputs sampled after release. No changed pulse is generated by reset itself.
- Inputs that toggle faster than one clock period may be missed. Only sampled values are encoded.

## Test plan
- Reset: hold rst_n=0 with a..d=1111 for 5 cycles -> e1,e0,valid,multi,changed all 0 throughout. Assert rst_n low asynchronously between edges -> outputs go to 0 immediately.
- One-hot sweep with SYNC_STAGES=2: a, b, c and d high in turn, each held 10 cycles -> {e1,e0}=00, 01, 10, 11, with valid=1 and multi=0. Each new code appears 3 edges after the input change, and changed pulses for 1 cycle at each transition.
- Idle: a..d=0000 -> {e1,e0}=00, valid=0, multi=0. Going from a=1 to all-zero -> changed pulses, because valid drops.
- Multi-hot priority: {d,c,b,a}=0110 -> 10, multi=1. 1111 -> 11, multi=1. 0011 -> 01, multi=1. Changing 1111 to 1001 -> changed stays 0, because the code stays 11.
- Latency check with SYNC_STAGES=0 and 3: a step on d -> outputs update after exactly 1 edge and 4 edges respectively.
- Reset mid-stream: toggle inputs every 3 cycles, pulse rst_n low for 2 ns mid-cycle -> outputs clear immediately. After release, outputs follow the new inputs with full latency and no spurious changed pulse.
